// File: rtl/nibble_serial_bridge.sv
// Bit-serial front end for a W-bit two-operand datapath: shifts in A then B,
// presents them in parallel, samples the result after LAT edges and shifts it out.
module nibble_serial_bridge #(
    parameter int W   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_in,
    input  logic         s_in_valid,
    output logic [W-1:0] a_out,
    output logic [W-1:0] b_out,
    output logic         op_valid,
    input  logic [W-1:0] o_in,
    output logic         s_out,
    output logic         s_out_valid,
    output logic         busy
);

    localparam int CW = $clog2(2 * W);
    localparam int TW = $clog2(W);

    localparam logic [1:0] ST_RX   = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_TX   = 2'd2;

    localparam logic [CW-1:0] BIT_LAST = CW'(2 * W - 1);
    localparam logic [TW-1:0] TX_LAST  = TW'(W - 1);
    localparam logic [3:0]    WAIT_INIT = 4'(LAT);

    logic [1:0]     r_state;
    logic [CW-1:0]  r_bit_cnt;
    logic [2*W-2:0] r_shift;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_op_valid;
    logic [3:0]     r_wait;
    logic [W-1:0]   r_tx;
    logic [TW-1:0]  r_tx_cnt;
    logic           r_s_out;
    logic           r_s_out_valid;
    logic           r_busy;

    // Receive/hold/transmit sequencer; every output is a register image.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RX;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op_valid    <= 1'b0;
            r_wait        <= 4'd0;
            r_tx          <= '0;
            r_tx_cnt      <= '0;
            r_s_out       <= 1'b0;
            r_s_out_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_op_valid <= 1'b0;
            case (r_state)
                ST_RX: begin
                    if (s_in_valid) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            // final bit bypasses the shifter straight into b_out[0]
                            r_a        <= r_shift[2*W-2:W-1];
                            r_b        <= {r_shift[W-2:0], s_in};
                            r_shift    <= '0;
                            r_bit_cnt  <= '0;
                            r_op_valid <= 1'b1;
                            r_wait     <= WAIT_INIT;
                            r_state    <= ST_HOLD;
                            r_busy     <= 1'b1;
                        end else begin
                            r_shift   <= {r_shift[2*W-3:0], s_in};
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_wait == 4'd1) begin
                        r_tx          <= {o_in[W-2:0], 1'b0};
                        r_s_out       <= o_in[W-1];
                        r_s_out_valid <= 1'b1;
                        r_tx_cnt      <= '0;
                        r_state       <= ST_TX;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                ST_TX: begin
                    if (r_tx_cnt == TX_LAST) begin
                        r_state       <= ST_RX;
                        r_s_out       <= 1'b0;
                        r_s_out_valid <= 1'b0;
                        r_busy        <= 1'b0;
                    end else begin
                        r_s_out  <= r_tx[W-1];
                        r_tx     <= {r_tx[W-2:0], 1'b0};
                        r_tx_cnt <= r_tx_cnt + TW'(1);
                    end
                end
                default: begin
                    r_state       <= ST_RX;
                    r_bit_cnt     <= '0;
                    r_s_out       <= 1'b0;
                    r_s_out_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign op_valid    = r_op_valid;
    assign s_out       = r_s_out;
    assign s_out_valid = r_s_out_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_nibble_serial_bridge.sv
// Self-checking bench: a LAT=1 instance closes the loop with O = A ^ B under a
// scoreboard; a LAT=3 instance checks the exact sample edge.
module tb_nibble_serial_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in;
    logic       s_in_valid;
    logic       sel3;
    logic [3:0] o_in3;

    logic [3:0] a1, b1, a3, b3, o1;
    logic       opv1, so1, sov1, busy1;
    logic       opv3, so3, sov3, busy3;
    logic       v1, v3;

    int checks   = 0;
    int failures = 0;
    int run_len  = 0;
    bit prev_sov = 1'b0;
    bit chk_len  = 1'b1;

    logic [7:0] exp_op[$];
    logic       exp_bit[$];

    always #5 clk = ~clk;

    assign v1 = s_in_valid & ~sel3;
    assign v3 = s_in_valid & sel3;
    assign o1 = a1 ^ b1;

    nibble_serial_bridge #(.W(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_valid(v1),
        .a_out(a1), .b_out(b1), .op_valid(opv1), .o_in(o1),
        .s_out(so1), .s_out_valid(sov1), .busy(busy1)
    );

    nibble_serial_bridge #(.W(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .s_in(s_in), .s_in_valid(v3),
        .a_out(a3), .b_out(b3), .op_valid(opv3), .o_in(o_in3),
        .s_out(so3), .s_out_valid(sov3), .busy(busy3)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        bit         gap;
        logic [3:0] exp_o;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [3:0] b, input int nbits);
        logic [3:0] x;
        x = a ^ b;
        exp_op.push_back({a, b});
        for (int i = 0; i < nbits; i++) exp_bit.push_back(x[3-i]);
    endtask

    // Called at a negedge; drives one bit per cycle, returns at a negedge.
    task automatic send_pair(input logic [3:0] a, input logic [3:0] b, input bit gap, input bit push);
        logic [7:0] bits;
        bits = {a, b};
        if (push) push_exp(a, b, 4);
        for (int i = 7; i >= 0; i--) begin
            s_in = bits[i];
            s_in_valid = 1'b1;
            @(negedge clk);
            if (gap && i > 0) begin
                s_in = 1'b0;
                s_in_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy1 !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_idle timeout busy=%0b", busy1);
        end
    endtask

    // Scoreboard monitor for the LAT=1 instance.
    always @(negedge clk) begin
        if (opv1) begin
            if (exp_op.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL op_valid_unexpected actual=%0h%0h expected=none", a1, b1);
            end else begin
                chk("op_ab", {a1, b1}, exp_op.pop_front());
            end
        end
        if (sov1) begin
            if (exp_bit.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_out_unexpected actual=%0b expected=none", so1);
            end else begin
                chk("s_out_bit", {7'd0, so1}, {7'd0, exp_bit.pop_front()});
            end
            run_len++;
        end else begin
            if (prev_sov && chk_len) begin
                chk("burst_len", 8'(run_len), 8'd4);
                chk("busy_after_burst", {7'd0, busy1}, 8'd0);
            end
            run_len = 0;
        end
        prev_sov = sov1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] lat_exp;
        int n;
        vecs[0] = '{a: 4'b1111, b: 4'b0010, gap: 1'b0, exp_o: 4'b1101};
        vecs[1] = '{a: 4'b1111, b: 4'b0010, gap: 1'b1, exp_o: 4'b1101};
        vecs[2] = '{a: 4'b1010, b: 4'b0101, gap: 1'b0, exp_o: 4'b1111};
        vecs[3] = '{a: 4'b0000, b: 4'b1111, gap: 1'b1, exp_o: 4'b1111};
        vecs[4] = '{a: 4'b1001, b: 4'b1001, gap: 1'b0, exp_o: 4'b0000};
        vecs[5] = '{a: 4'b0110, b: 4'b1100, gap: 1'b0, exp_o: 4'b1010};

        rst = 1'b1; s_in = 1'b0; s_in_valid = 1'b0; sel3 = 1'b0; o_in3 = 4'b0101;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_a", {4'd0, a1}, 8'd0);
        chk("rst_b", {4'd0, b1}, 8'd0);
        chk("rst_flags", {4'd0, opv1, so1, sov1, busy1}, 8'd0);

        // Table vectors, each pair starting the first cycle busy is low.
        for (int k = 0; k < 6; k++) begin
            exp_op.push_back({vecs[k].a, vecs[k].b});
            for (int i = 3; i >= 0; i--) exp_bit.push_back(vecs[k].exp_o[i]);
            send_pair(vecs[k].a, vecs[k].b, vecs[k].gap, 1'b0);
            chk("busy_after_load", {7'd0, busy1}, 8'd1);
            wait_idle();
        end

        // Bits offered while busy are dropped.
        send_pair(4'b1111, 4'b0010, 1'b0, 1'b1);
        n = 0;
        while (busy1 && n < 20) begin
            s_in = 1'b1;
            s_in_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        send_pair(4'b0000, 4'b0000, 1'b0, 1'b1);
        wait_idle();

        // Reset mid-RX after 5 bits.
        for (int i = 0; i < 5; i++) begin
            s_in = 1'b1;
            s_in_valid = 1'b1;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rx_rst_ab", {a1, b1}, 8'h00);
        chk("rx_rst_flags", {4'd0, opv1, so1, sov1, busy1}, 8'd0);
        send_pair(4'b1001, 4'b0110, 1'b0, 1'b1);
        wait_idle();

        // Reset during the second TX cycle.
        chk_len = 1'b0;
        push_exp(4'b1100, 4'b1010, 2);
        send_pair(4'b1100, 4'b1010, 1'b0, 1'b0);
        n = 0;
        while (!sov1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tx_rst_sov", {7'd0, sov1}, 8'd0);
        chk("tx_rst_busy", {7'd0, busy1}, 8'd0);
        chk("tx_rst_ab", {a1, b1}, 8'h00);
        @(negedge clk);
        chk_len = 1'b1;
        send_pair(4'b0011, 4'b0101, 1'b0, 1'b1);
        wait_idle();

        // LAT=3 instance: o_in changes after the 2nd edge, back after the 3rd.
        sel3 = 1'b1;
        send_pair(4'b1100, 4'b0011, 1'b0, 1'b0);
        chk("lat3_opv", {7'd0, opv3}, 8'd1);
        chk("lat3_ab", {a3, b3}, 8'hC3);
        @(negedge clk);
        chk("lat3_e1_sov", {7'd0, sov3}, 8'd0);
        @(negedge clk);
        chk("lat3_e2_sov", {6'd0, sov3, busy3}, 8'd1);
        o_in3 = 4'b1010;
        @(negedge clk);
        o_in3 = 4'b0101;
        lat_exp = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            chk("lat3_sout", {6'd0, sov3, so3}, {6'd0, 1'b1, lat_exp[i]});
            @(negedge clk);
        end
        chk("lat3_end", {6'd0, sov3, busy3}, 8'd0);
        sel3 = 1'b0;

        repeat (4) @(negedge clk);
        chk("sb_op_empty", 8'(exp_op.size()), 8'd0);
        chk("sb_bit_empty", 8'(exp_bit.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
